// File: rtl/lsu.sv
// Load/store unit: latches one request, drives the mem port for one store or MEM_LAT load cycles, then returns the extended data.
// Response holds until resp_ready. `LSU_MISALIGN_TRAP_EN` answers misaligned requests with resp_err and never issues them.
module lsu #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ena,
  output logic        mem_wen,
  output logic [3:0]  mem_mask,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q;
  logic [CW-1:0] cnt;
  logic [63:0]   rdata_q;
  logic          err_q;
  logic          trap;
  logic          last_beat;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
  assign trap = misalign;
`else
  assign trap = 1'b0;
`endif

  assign last_beat = (cnt == CW'(MEM_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_ena    = 1'b0;
    mem_wen    = 1'b0;
    mem_mask   = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = trap ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_ena  = 1'b1;
        mem_wen  = req_q.wen;
        mem_mask = {req_q.size == 2'd0, req_q.size == 2'd1, req_q.size == 2'd2, req_q.size == 2'd3};
        if (req_q.wen || last_beat) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdata_q is cleared on accept so stores and trapped requests respond with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        req_q.wen   <= req_wen;
        req_q.size  <= req_size;
        req_q.uns   <= req_unsigned;
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        rdata_q     <= '0;
        err_q       <= trap;
        cnt         <= '0;
      end
      if (state == ISSUE && !req_q.wen) begin
        if (last_beat) begin
          rdata_q <= mem_rdata;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    resp_rdata = rdata_q;
    case (req_q.size)
      2'd0: resp_rdata = req_q.uns ? {56'd0, rdata_q[7:0]}  : {{56{rdata_q[7]}},  rdata_q[7:0]};
      2'd1: resp_rdata = req_q.uns ? {48'd0, rdata_q[15:0]} : {{48{rdata_q[15]}}, rdata_q[15:0]};
      2'd2: resp_rdata = req_q.uns ? {32'd0, rdata_q[31:0]} : {{32{rdata_q[31]}}, rdata_q[31:0]};
      default: resp_rdata = rdata_q;
    endcase
  end

  assign resp_err  = err_q;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata << {req_q.addr[2:0], 3'b000};

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with MEM_LAT=3; compile with or without LSU_MISALIGN_TRAP_EN.
module tb_lsu;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_ena, mem_wen;
  logic [3:0]  mem_mask;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int passed = 0;
  int wr_cnt = 0;
  int ena_cnt = 0;
  logic [63:0] wr_dat = '0;

  lsu #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ena(mem_ena),
    .mem_wen(mem_wen), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: counts enable cycles and committed writes at each edge.
  always @(posedge clk) begin
    if (mem_ena) ena_cnt++;
    if (mem_ena && mem_wen) begin
      wr_cnt++;
      wr_dat = mem_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %0h want 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %0h want 0", resp_valid); else passed++;
    checks++; if (resp_rdata !== 64'd0) $display("FAIL rst_resp_rdata got %0h want 0", resp_rdata); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %0h want 0", resp_err); else passed++;
    checks++; if (mem_ena !== 1'b0) $display("FAIL rst_mem_ena got %0h want 0", mem_ena); else passed++;
    checks++; if (mem_wen !== 1'b0) $display("FAIL rst_mem_wen got %0h want 0", mem_wen); else passed++;
    checks++; if (mem_mask !== 4'd0) $display("FAIL rst_mem_mask got %0h want 0", mem_mask); else passed++;
    checks++; if (mem_addr !== 64'd0) $display("FAIL rst_mem_addr got %0h want 0", mem_addr); else passed++;
    checks++; if (mem_wdata !== 64'd0) $display("FAIL rst_mem_wdata got %0h want 0", mem_wdata); else passed++;
  endtask

  task automatic test_store_word;
    int w0;
    w0 = wr_cnt;
    checks++; if (req_ready !== 1'b1) $display("FAIL st_req_ready got %0h want 1", req_ready); else passed++;
    send(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF);
    checks++; if (mem_ena !== 1'b1) $display("FAIL st_mem_ena got %0h want 1", mem_ena); else passed++;
    checks++; if (mem_wen !== 1'b1) $display("FAIL st_mem_wen got %0h want 1", mem_wen); else passed++;
    checks++; if (mem_mask !== 4'b0010) $display("FAIL st_mem_mask got %b want 0010", mem_mask); else passed++;
    checks++; if (mem_wdata !== 64'hDEAD_BEEF_0000_0000) $display("FAIL st_mem_wdata got %h want deadbeef00000000", mem_wdata); else passed++;
    checks++; if (mem_addr !== 64'h8000_0004) $display("FAIL st_mem_addr got %h want 80000004", mem_addr); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL st_resp_early got %0h want 0", resp_valid); else passed++;
    tick();
    checks++; if (mem_ena !== 1'b0) $display("FAIL st_ena_off got %0h want 0", mem_ena); else passed++;
    checks++; if (resp_valid !== 1'b1) $display("FAIL st_resp_valid got %0h want 1", resp_valid); else passed++;
    checks++; if (resp_rdata !== 64'd0) $display("FAIL st_resp_rdata got %h want 0", resp_rdata); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL st_resp_err got %0h want 0", resp_err); else passed++;
    checks++; if (wr_cnt !== w0 + 1) $display("FAIL st_wr_cnt got %0d want %0d", wr_cnt, w0 + 1); else passed++;
    checks++; if (wr_dat !== 64'hDEAD_BEEF_0000_0000) $display("FAIL st_wr_dat got %h want deadbeef00000000", wr_dat); else passed++;
    checks++; if (mem_wdata !== 64'hDEAD_BEEF_0000_0000) $display("FAIL st_wdata_hold got %h want deadbeef00000000", mem_wdata); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL st_idle got %0h want 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL st_resp_drop got %0h want 0", resp_valid); else passed++;
  endtask

  // Drives distinct junk on mem_rdata until the final ISSUE cycle so a wrong sample point shows up.
  task automatic do_load(input logic [1:0] size, input logic uns, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] exp, input string name);
    logic [3:0] mask_exp;
    mask_exp = 4'b1000 >> size;
    send(1'b0, size, uns, addr, 64'd0);
    for (int c = 1; c <= LAT; c++) begin
      checks++; if (mem_ena !== 1'b1) $display("FAIL %s_ena_c%0d got %0h want 1", name, c, mem_ena); else passed++;
      if (c == 1) begin
        checks++; if (mem_mask !== mask_exp) $display("FAIL %s_mask got %b want %b", name, mem_mask, mask_exp); else passed++;
        checks++; if (mem_wen !== 1'b0) $display("FAIL %s_wen got %0h want 0", name, mem_wen); else passed++;
      end
      mem_rdata = (c == LAT) ? data : (64'hA5A5_5A5A_C3C3_3C3C ^ 64'(c));
      tick();
    end
    checks++; if (mem_ena !== 1'b0) $display("FAIL %s_ena_off got %0h want 0", name, mem_ena); else passed++;
    checks++; if (resp_valid !== 1'b1) $display("FAIL %s_resp_valid got %0h want 1", name, resp_valid); else passed++;
    checks++; if (resp_rdata !== exp) $display("FAIL %s_rdata got %h want %h", name, resp_rdata, exp); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL %s_err got %0h want 0", name, resp_err); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mem_rdata = 64'd0;
  endtask

  task automatic test_load_ext;
    do_load(2'd0, 1'b0, 64'h8000_0007, 64'h80, 64'hFFFF_FFFF_FFFF_FF80, "lb_s");
    do_load(2'd0, 1'b1, 64'h8000_0007, 64'h80, 64'h0000_0000_0000_0080, "lb_u");
    do_load(2'd1, 1'b0, 64'h8000_0002, 64'h8001, 64'hFFFF_FFFF_FFFF_8001, "lh_s");
    do_load(2'd1, 1'b1, 64'h8000_0002, 64'h8001, 64'h0000_0000_0000_8001, "lh_u");
    do_load(2'd2, 1'b0, 64'h8000_0004, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, "lw_s");
    do_load(2'd2, 1'b1, 64'h8000_0004, 64'h8000_0000, 64'h0000_0000_8000_0000, "lw_u");
    do_load(2'd2, 1'b0, 64'h8000_0000, 64'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, "lw_pos");
  endtask

  task automatic test_load_double;
    int e0;
    e0 = ena_cnt;
    do_load(2'd3, 1'b0, 64'h8000_0008, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, "ld");
    checks++; if (ena_cnt !== e0 + LAT) $display("FAIL ld_ena_cycles got %0d want %0d", ena_cnt - e0, LAT); else passed++;
  endtask

  task automatic test_backpressure;
    send(1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'd0);
    mem_rdata = 64'h1234_5678;
    for (int c = 0; c < LAT; c++) tick();
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_addr = 64'h40; req_wdata = 64'h55;
    for (int k = 0; k < 5; k++) begin
      checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid_k%0d got %0h want 1", k, resp_valid); else passed++;
      checks++; if (resp_rdata !== 64'h1234_5678) $display("FAIL bp_rdata_k%0d got %h want 12345678", k, resp_rdata); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready_k%0d got %0h want 0", k, req_ready); else passed++;
      checks++; if (mem_ena !== 1'b0) $display("FAIL bp_mem_ena_k%0d got %0h want 0", k, mem_ena); else passed++;
      tick();
    end
    req_valid = 1'b0;
    mem_rdata = 64'd0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL bp_idle got %0h want 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL bp_resp_drop got %0h want 0", resp_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    int w0;
    w0 = wr_cnt;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h8000_0100; req_wdata = 64'h0BAD_F00D_1234_5678;
    tick();
    for (int c = 1; c <= 6; c++) begin
      checks++; if (mem_ena !== ((c % 3) == 1)) $display("FAIL b2b_ena_c%0d got %0h want %0h", c, mem_ena, ((c % 3) == 1)); else passed++;
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    resp_ready = 1'b0;
    checks++; if (wr_cnt !== w0 + 3) $display("FAIL b2b_writes got %0d want %0d", wr_cnt - w0, 3); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL b2b_idle got %0h want 1", req_ready); else passed++;
  endtask

  task automatic test_misalign;
    int e0;
    e0 = ena_cnt;
    send(1'b0, 2'd1, 1'b0, 64'h8000_0001, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (resp_valid !== 1'b1) $display("FAIL mis_valid got %0h want 1", resp_valid); else passed++;
    checks++; if (resp_err !== 1'b1) $display("FAIL mis_err got %0h want 1", resp_err); else passed++;
    checks++; if (resp_rdata !== 64'd0) $display("FAIL mis_rdata got %h want 0", resp_rdata); else passed++;
    checks++; if (mem_ena !== 1'b0) $display("FAIL mis_ena got %0h want 0", mem_ena); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if (ena_cnt !== e0) $display("FAIL mis_ena_cycles got %0d want 0", ena_cnt - e0); else passed++;
`else
    checks++; if (mem_ena !== 1'b1) $display("FAIL mis_ena got %0h want 1", mem_ena); else passed++;
    checks++; if (mem_mask !== 4'b0100) $display("FAIL mis_mask got %b want 0100", mem_mask); else passed++;
    mem_rdata = 64'd0;
    for (int c = 0; c < LAT; c++) tick();
    checks++; if (resp_valid !== 1'b1) $display("FAIL mis_valid got %0h want 1", resp_valid); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL mis_err got %0h want 0", resp_err); else passed++;
    checks++; if (resp_rdata !== 64'd0) $display("FAIL mis_rdata got %h want 0", resp_rdata); else passed++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if (ena_cnt !== e0 + LAT) $display("FAIL mis_ena_cycles got %0d want %0d", ena_cnt - e0, LAT); else passed++;
`endif
    checks++; if (req_ready !== 1'b1) $display("FAIL mis_idle got %0h want 1", req_ready); else passed++;
  endtask

  task automatic test_reset_mid_issue;
    int w0;
    w0 = wr_cnt;
    send(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h0000_0000_CAFE_F00D);
    checks++; if (mem_ena !== 1'b1) $display("FAIL rmi_ena_pre got %0h want 1", mem_ena); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_ena !== 1'b0) $display("FAIL rmi_ena got %0h want 0", mem_ena); else passed++;
    checks++; if (mem_wen !== 1'b0) $display("FAIL rmi_wen got %0h want 0", mem_wen); else passed++;
    checks++; if (mem_mask !== 4'd0) $display("FAIL rmi_mask got %b want 0000", mem_mask); else passed++;
    checks++; if (mem_addr !== 64'd0) $display("FAIL rmi_addr got %h want 0", mem_addr); else passed++;
    checks++; if (mem_wdata !== 64'd0) $display("FAIL rmi_wdata got %h want 0", mem_wdata); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL rmi_req_ready got %0h want 1", req_ready); else passed++;
    tick();
    checks++; if (wr_cnt !== w0) $display("FAIL rmi_no_write got %0d want %0d", wr_cnt, w0); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0) $display("FAIL rmi_resp_valid got %0h want 0", resp_valid); else passed++;
    checks++; if (mem_ena !== 1'b0) $display("FAIL rmi_idle_ena got %0h want 0", mem_ena); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_store_word();
    test_load_ext();
    test_load_double();
    test_backpressure();
    test_back_to_back();
    test_misalign();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
